// File: rtl/sgpr_rollback_pkg.sv
// rtl/sgpr_rollback_pkg.sv - FSM state type and default sizing for the rollback register file
package sgpr_rollback_pkg;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_ROLLBACK = 1'b1
    } state_e;

    localparam int DEF_NUM_REGS   = 32;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_LOG_DEPTH  = 8;

endpackage

// File: rtl/sgpr_undo_log.sv
// rtl/sgpr_undo_log.sv - LIFO of {addr, old value} undo entries
module sgpr_undo_log #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 8,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] top_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic [CW-1:0]    top_idx;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign top_idx = count_q - CW'(1);
    // Only meaningful while non-empty; the caller never pops an empty log.
    assign top_o   = mem_q[top_idx[PW-1:0]];

    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (push_i && !full_o) begin
            mem_d[count_q[PW-1:0]] = push_data_i;
            count_d = count_q + CW'(1);
        end else if (pop_i && !empty_o) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Entry storage needs no reset: the count alone defines what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/sgpr_rollback.sv
// rtl/sgpr_rollback.sv - register file with checkpoint and LIFO undo-log rollback
module sgpr_rollback
    import sgpr_rollback_pkg::*;
#(
    parameter int  NUM_REGS   = DEF_NUM_REGS,
    parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int  LOG_DEPTH  = DEF_LOG_DEPTH,
    localparam int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  test_en_i,
    input  logic [ADDR_WIDTH-1:0] raddr_a_i,
    input  logic [ADDR_WIDTH-1:0] raddr_b_i,
    output logic [DATA_WIDTH-1:0] rdata_a_o,
    output logic [DATA_WIDTH-1:0] rdata_b_o,
    input  logic [ADDR_WIDTH-1:0] waddr_a_i,
    input  logic [DATA_WIDTH-1:0] wdata_a_i,
    input  logic                  we_a_i,
    input  logic                  checkpoint_i,
    input  logic                  replay_i,
    output logic                  busy_o,
    output logic                  log_full_o,
    output logic                  overflow_o
);
    localparam int EW = ADDR_WIDTH + DATA_WIDTH;
    localparam int CW = $clog2(LOG_DEPTH + 1);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic                  overflow_q, overflow_d;

    logic                  log_push, log_pop, log_clear;
    logic                  log_full, log_empty;
    logic [EW-1:0]         log_top;
    logic [CW-1:0]         log_count;
    logic [ADDR_WIDTH-1:0] top_addr;
    logic [DATA_WIDTH-1:0] top_data;
    logic                  wr_valid;
    logic                  unused_test_en;

    assign unused_test_en = test_en_i;
    assign {top_addr, top_data} = log_top;
    assign wr_valid   = we_a_i && (waddr_a_i != '0) && (int'(waddr_a_i) < NUM_REGS);
    assign busy_o     = (state_q == ST_ROLLBACK);
    assign log_full_o = log_full;
    assign overflow_o = overflow_q;

    assign rdata_a_o = ((raddr_a_i != '0) && (int'(raddr_a_i) < NUM_REGS)) ? regs_q[raddr_a_i] : '0;
    assign rdata_b_o = ((raddr_b_i != '0) && (int'(raddr_b_i) < NUM_REGS)) ? regs_q[raddr_b_i] : '0;

    always_comb begin
        state_d    = state_q;
        regs_d     = regs_q;
        overflow_d = overflow_q;
        log_push   = 1'b0;
        log_pop    = 1'b0;
        log_clear  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (replay_i) begin
                    // Replay wins; a same-cycle write or checkpoint is discarded.
                    if (!log_empty) begin
                        state_d = ST_ROLLBACK;
                    end
                end else begin
                    if (wr_valid) begin
                        regs_d[waddr_a_i] = wdata_a_i;
                    end
                    if (checkpoint_i) begin
                        log_clear  = 1'b1;
                        overflow_d = 1'b0;
                    end else if (wr_valid) begin
                        if (log_full) begin
                            overflow_d = 1'b1;
                        end else begin
                            log_push = 1'b1;
                        end
                    end
                end
            end
            ST_ROLLBACK: begin
                log_pop          = 1'b1;
                regs_d[top_addr] = top_data;
                if (log_count == CW'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            overflow_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            overflow_q <= overflow_d;
            regs_q     <= regs_d;
        end
    end

    sgpr_undo_log #(
        .WIDTH (EW),
        .DEPTH (LOG_DEPTH)
    ) u_undo_log (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (log_clear),
        .push_i      (log_push),
        .push_data_i ({waddr_a_i, regs_q[waddr_a_i]}),
        .pop_i       (log_pop),
        .top_o       (log_top),
        .count_o     (log_count),
        .full_o      (log_full),
        .empty_o     (log_empty)
    );

endmodule

// File: tb/tb_sgpr_rollback.sv
// tb/tb_sgpr_rollback.sv - directed self-checking bench for sgpr_rollback
module tb_sgpr_rollback;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          test_en = 1'b0;
    logic [AW-1:0] raddr_a = '0, raddr_b = '0, waddr = '0;
    logic [31:0]   rdata_a, rdata_b;
    logic [31:0]   wdata = '0;
    logic          we = 1'b0, cp = 1'b0, rp = 1'b0;
    logic          busy, full, ovf;

    int vec_cnt = 0;
    int err_cnt = 0;

    sgpr_rollback #(.NUM_REGS(32), .DATA_WIDTH(32), .LOG_DEPTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .test_en_i    (test_en),
        .raddr_a_i    (raddr_a),
        .raddr_b_i    (raddr_b),
        .rdata_a_o    (rdata_a),
        .rdata_b_o    (rdata_b),
        .waddr_a_i    (waddr),
        .wdata_a_i    (wdata),
        .we_a_i       (we),
        .checkpoint_i (cp),
        .replay_i     (rp),
        .busy_o       (busy),
        .log_full_o   (full),
        .overflow_o   (ovf)
    );

    always #5 clk = ~clk;

    task automatic wr(input int a, input logic [31:0] d);
        waddr = a[AW-1:0]; wdata = d; we = 1'b1;
        @(posedge clk); #1;
        we = 1'b0;
    endtask

    task automatic checkpoint();
        cp = 1'b1;
        @(posedge clk); #1;
        cp = 1'b0;
    endtask

    task automatic rd(input int a, output logic [31:0] d);
        raddr_a = a[AW-1:0];
        #1;
        d = rdata_a;
    endtask

    // Counts consecutive busy cycles, starting right after a replay edge.
    task automatic count_busy(output int n);
        n = 0;
        for (int k = 0; k < 40 && busy; k++) begin
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic replay(output int n);
        rp = 1'b1;
        @(posedge clk); #1;
        rp = 1'b0;
        count_busy(n);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        #12;
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy got=%b exp=0", busy); end
        vec_cnt++; if (full !== 1'b0) begin err_cnt++; $display("FAIL reset_full got=%b exp=0", full); end
        vec_cnt++; if (ovf !== 1'b0) begin err_cnt++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        rd(1, d);
        vec_cnt++; if (d !== 32'h0) begin err_cnt++; $display("FAIL reset_r1 got=%h exp=0", d); end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_rollback();
        logic [31:0] d;
        for (int i = 1; i < 32; i++) wr(i, i);
        vec_cnt++; if (full !== 1'b1) begin err_cnt++; $display("FAIL fill_full got=%b exp=1", full); end
        vec_cnt++; if (ovf !== 1'b1) begin err_cnt++; $display("FAIL fill_ovf got=%b exp=1", ovf); end
        checkpoint();
        vec_cnt++; if (ovf !== 1'b0) begin err_cnt++; $display("FAIL cp_clears_ovf got=%b exp=0", ovf); end
        vec_cnt++; if (full !== 1'b0) begin err_cnt++; $display("FAIL cp_clears_full got=%b exp=0", full); end
        wr(5, 32'hAA);
        wr(7, 32'hBB);
        rd(5, d);
        vec_cnt++; if (d !== 32'hAA) begin err_cnt++; $display("FAIL r5_written got=%h exp=aa", d); end
        rp = 1'b1;
        @(posedge clk); #1;
        rp = 1'b0;
        vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL rb_busy1 got=%b exp=1", busy); end
        rd(7, d);
        vec_cnt++; if (d !== 32'hBB) begin err_cnt++; $display("FAIL rb_r7_before got=%h exp=bb", d); end
        @(posedge clk); #1;
        vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL rb_busy2 got=%b exp=1", busy); end
        rd(7, d);
        vec_cnt++; if (d !== 32'h7) begin err_cnt++; $display("FAIL rb_r7_partial got=%h exp=7", d); end
        rd(5, d);
        vec_cnt++; if (d !== 32'hAA) begin err_cnt++; $display("FAIL rb_r5_partial got=%h exp=aa", d); end
        @(posedge clk); #1;
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rb_busy_end got=%b exp=0", busy); end
        rd(5, d);
        vec_cnt++; if (d !== 32'h5) begin err_cnt++; $display("FAIL rb_r5_final got=%h exp=5", d); end
    endtask

    task automatic test_lifo();
        logic [31:0] d;
        int n;
        checkpoint();
        wr(3, 32'h11);
        wr(3, 32'h22);
        replay(n);
        vec_cnt++; if (n !== 2) begin err_cnt++; $display("FAIL lifo_busy_cycles got=%0d exp=2", n); end
        rd(3, d);
        vec_cnt++; if (d !== 32'h3) begin err_cnt++; $display("FAIL lifo_r3 got=%h exp=3", d); end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        logic [31:0] e;
        int n;
        checkpoint();
        for (int i = 0; i < 10; i++) begin
            wr(10 + i, 32'h100 + i);
            vec_cnt++; if (full !== (i >= 7)) begin err_cnt++; $display("FAIL ovf_full_w%0d got=%b exp=%b", i, full, (i >= 7)); end
            vec_cnt++; if (ovf !== (i >= 8)) begin err_cnt++; $display("FAIL ovf_flag_w%0d got=%b exp=%b", i, ovf, (i >= 8)); end
        end
        replay(n);
        vec_cnt++; if (n !== 8) begin err_cnt++; $display("FAIL ovf_busy_cycles got=%0d exp=8", n); end
        for (int i = 0; i < 10; i++) begin
            e = (i < 8) ? 32'(10 + i) : 32'h100 + i;
            rd(10 + i, d);
            vec_cnt++; if (d !== e) begin err_cnt++; $display("FAIL ovf_r%0d got=%h exp=%h", 10 + i, d, e); end
        end
        vec_cnt++; if (ovf !== 1'b1) begin err_cnt++; $display("FAIL ovf_sticky got=%b exp=1", ovf); end
        vec_cnt++; if (full !== 1'b0) begin err_cnt++; $display("FAIL ovf_full_after got=%b exp=0", full); end
        checkpoint();
        vec_cnt++; if (ovf !== 1'b0) begin err_cnt++; $display("FAIL ovf_cleared got=%b exp=0", ovf); end
    endtask

    task automatic test_ignore_during_rollback();
        logic [31:0] d;
        int n;
        checkpoint();
        wr(6, 32'h66);
        wr(2, 32'h22);
        rp = 1'b1;
        @(posedge clk); #1;
        waddr = 5'd20; wdata = 32'hDEAD; we = 1'b1; cp = 1'b1;
        count_busy(n);
        we = 1'b0; cp = 1'b0; rp = 1'b0;
        vec_cnt++; if (n !== 2) begin err_cnt++; $display("FAIL ign_busy_cycles got=%0d exp=2", n); end
        rd(20, d);
        vec_cnt++; if (d !== 32'd20) begin err_cnt++; $display("FAIL ign_r20 got=%h exp=14", d); end
        rd(6, d);
        vec_cnt++; if (d !== 32'd6) begin err_cnt++; $display("FAIL ign_r6 got=%h exp=6", d); end
        rd(2, d);
        vec_cnt++; if (d !== 32'd2) begin err_cnt++; $display("FAIL ign_r2 got=%h exp=2", d); end
    endtask

    task automatic test_same_cycle();
        logic [31:0] d;
        int n;
        checkpoint();
        wr(8, 32'h88);
        waddr = 5'd9; wdata = 32'h99; we = 1'b1; rp = 1'b1;
        @(posedge clk); #1;
        we = 1'b0; rp = 1'b0;
        count_busy(n);
        vec_cnt++; if (n !== 1) begin err_cnt++; $display("FAIL rpwr_busy got=%0d exp=1", n); end
        rd(9, d);
        vec_cnt++; if (d !== 32'h9) begin err_cnt++; $display("FAIL rpwr_r9 got=%h exp=9", d); end
        rd(8, d);
        vec_cnt++; if (d !== 32'h8) begin err_cnt++; $display("FAIL rpwr_r8 got=%h exp=8", d); end
        wr(8, 32'h88);
        rp = 1'b1; cp = 1'b1;
        @(posedge clk); #1;
        rp = 1'b0; cp = 1'b0;
        count_busy(n);
        vec_cnt++; if (n !== 1) begin err_cnt++; $display("FAIL rpcp_busy got=%0d exp=1", n); end
        rd(8, d);
        vec_cnt++; if (d !== 32'h8) begin err_cnt++; $display("FAIL rpcp_r8 got=%h exp=8", d); end
        wr(11, 32'h55);
        waddr = 5'd4; wdata = 32'h44; we = 1'b1; cp = 1'b1;
        @(posedge clk); #1;
        we = 1'b0; cp = 1'b0;
        rd(4, d);
        vec_cnt++; if (d !== 32'h44) begin err_cnt++; $display("FAIL wrcp_r4 got=%h exp=44", d); end
        replay(n);
        vec_cnt++; if (n !== 0) begin err_cnt++; $display("FAIL wrcp_log_empty got=%0d exp=0", n); end
        rd(4, d);
        vec_cnt++; if (d !== 32'h44) begin err_cnt++; $display("FAIL wrcp_r4_kept got=%h exp=44", d); end
        rd(11, d);
        vec_cnt++; if (d !== 32'h55) begin err_cnt++; $display("FAIL wrcp_r11_kept got=%h exp=55", d); end
    endtask

    task automatic test_r0_empty();
        logic [31:0] d;
        int n;
        checkpoint();
        wr(0, 32'hFF);
        rd(0, d);
        raddr_b = 5'd0;
        #1;
        vec_cnt++; if (d !== 32'h0) begin err_cnt++; $display("FAIL r0_port_a got=%h exp=0", d); end
        vec_cnt++; if (rdata_b !== 32'h0) begin err_cnt++; $display("FAIL r0_port_b got=%h exp=0", rdata_b); end
        replay(n);
        vec_cnt++; if (n !== 0) begin err_cnt++; $display("FAIL r0_not_logged got=%0d exp=0", n); end
    endtask

    task automatic test_reset_mid_rollback();
        logic [31:0] d;
        int n;
        checkpoint();
        for (int i = 1; i < 10; i++) wr(i, 32'hF0 + i);
        rp = 1'b1;
        @(posedge clk); #1;
        rp = 1'b0;
        @(posedge clk); #1;
        vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL mid_busy got=%b exp=1", busy); end
        #2 rst_n = 1'b0;
        #1;
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
        vec_cnt++; if (full !== 1'b0) begin err_cnt++; $display("FAIL mid_rst_full got=%b exp=0", full); end
        vec_cnt++; if (ovf !== 1'b0) begin err_cnt++; $display("FAIL mid_rst_ovf got=%b exp=0", ovf); end
        raddr_b = 5'd9;
        rd(1, d);
        vec_cnt++; if (d !== 32'h0) begin err_cnt++; $display("FAIL mid_rst_r1 got=%h exp=0", d); end
        vec_cnt++; if (rdata_b !== 32'h0) begin err_cnt++; $display("FAIL mid_rst_r9 got=%h exp=0", rdata_b); end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL post_rst_busy got=%b exp=0", busy); end
        replay(n);
        vec_cnt++; if (n !== 0) begin err_cnt++; $display("FAIL post_rst_log got=%0d exp=0", n); end
        rd(8, d);
        vec_cnt++; if (d !== 32'h0) begin err_cnt++; $display("FAIL post_rst_r8 got=%h exp=0", d); end
    endtask

    initial begin
        test_reset();
        test_basic_rollback();
        test_lifo();
        test_overflow();
        test_ignore_during_rollback();
        test_same_cycle();
        test_r0_empty();
        test_reset_mid_rollback();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
